// File: rtl/mixer_level_ctrl.sv
// Frame-synchronous level/shift controller for the bit-serial mix path.
// Accepts gain targets over valid/ready and ramps the mixer level by a fixed
// step once per I2S frame, so a word is never re-scaled mid-stream. A
// level-sensitive soft mute ramps the level to zero and back on release.
module mixer_level_ctrl #(
  parameter int W_LEVEL   = 7,
  parameter int MAX_LEVEL = 100,
  parameter int MAX_SHIFT = 8,
  parameter int STEP      = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lrclk_i,
  input  logic               mute_i,
  input  logic               req_valid_i,
  input  logic [W_LEVEL-1:0] req_level_i,
  input  logic [3:0]         req_shift_i,
  output logic               req_ready_o,
  output logic [W_LEVEL-1:0] level_o,
  output logic [3:0]         shift_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               frame_tick_o
);

  localparam logic [W_LEVEL-1:0] MAX_LVL_C = W_LEVEL'(MAX_LEVEL);
  localparam logic [W_LEVEL-1:0] STEP_C    = W_LEVEL'(STEP);
  localparam logic [3:0]         MAX_SH_C  = 4'(MAX_SHIFT);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t             state_q, state_d;
  logic               lrclk_q;
  logic               tick_q;
  logic [W_LEVEL-1:0] level_q, level_d;
  logic [W_LEVEL-1:0] tgt_level_q, tgt_level_d;
  logic [3:0]         shift_q, shift_d;
  logic [3:0]         tgt_shift_q, tgt_shift_d;
  logic               done_q, done_d;

  logic               xfer;
  logic               up;
  logic [W_LEVEL-1:0] eff_tgt;
  logic [W_LEVEL-1:0] diff;
  logic [W_LEVEL-1:0] stepv;
  logic [W_LEVEL-1:0] ramp_lvl;

  // Ready only in IDLE and never while reset is held, so nothing is taken
  // in the reset cycle itself.
  assign req_ready_o  = (state_q == IDLE) && !rst_i;
  assign xfer         = req_valid_i && req_ready_o;

  assign level_o      = level_q;
  assign shift_o      = shift_q;
  assign busy_o       = (state_q == RAMP);
  assign done_o       = done_q;
  assign frame_tick_o = tick_q;

  // Frame boundary: registered pulse the cycle after lrclk is seen falling.
  // lrclk_q clears on reset so a low lrclk at release gives no tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lrclk_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      lrclk_q <= lrclk_i;
      tick_q  <= lrclk_q & ~lrclk_i;
    end
  end

  // One ramp step toward the effective target, clipped to the remaining
  // distance so the level lands exactly on target and never overshoots.
  always_comb begin
    eff_tgt  = mute_i ? '0 : tgt_level_q;
    up       = (eff_tgt >= level_q);
    diff     = up ? (eff_tgt - level_q) : (level_q - eff_tgt);
    stepv    = (diff < STEP_C) ? diff : STEP_C;
    ramp_lvl = up ? (level_q + stepv) : (level_q - stepv);
  end

  // Next-state logic: accept targets in IDLE, step level/shift on frame ticks
  // in RAMP, and return to IDLE with a done pulse once the target is reached.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    shift_d     = shift_q;
    tgt_level_d = tgt_level_q;
    tgt_shift_d = tgt_shift_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          tgt_level_d = (req_level_i > MAX_LVL_C) ? MAX_LVL_C : req_level_i;
          tgt_shift_d = (req_shift_i > MAX_SH_C) ? MAX_SH_C : req_shift_i;
          state_d     = RAMP;
        end else if (level_q != eff_tgt) begin
          // mute edge (or its release) moves the target with no request
          state_d = RAMP;
        end
      end
      RAMP: begin
        // eff_tgt is re-read every tick, so a mute change reverses the ramp
        // in place without leaving RAMP
        if (tick_q) begin
          level_d = ramp_lvl;
          shift_d = tgt_shift_q;
          if (ramp_lvl == eff_tgt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any ramp in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      level_q     <= '0;
      shift_q     <= '0;
      tgt_level_q <= '0;
      tgt_shift_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      shift_q     <= shift_d;
      tgt_level_q <= tgt_level_d;
      tgt_shift_q <= tgt_shift_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_mixer_level_ctrl.sv
// Bench for mixer_level_ctrl: a step=1 instance for most scenarios and a
// step=4 instance for clamp/step. Expected levels are pushed to a queue when
// a request or mute change is driven and popped after each frame tick.
module tb_mixer_level_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lrclk = 1'b0;
  logic       mute = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_valid4 = 1'b0;
  logic [6:0] req_level = '0;
  logic [3:0] req_shift = '0;

  logic       ready1, busy1, done1, tick1;
  logic [6:0] level1;
  logic [3:0] shift1;
  logic       ready4, busy4, done4, tick4;
  logic [6:0] level4;
  logic [3:0] shift4;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [6:0] exp_q[$];

  mixer_level_ctrl #(.W_LEVEL(7), .MAX_LEVEL(100), .MAX_SHIFT(8), .STEP(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .lrclk_i(lrclk), .mute_i(mute),
    .req_valid_i(req_valid), .req_level_i(req_level), .req_shift_i(req_shift),
    .req_ready_o(ready1), .level_o(level1), .shift_o(shift1),
    .busy_o(busy1), .done_o(done1), .frame_tick_o(tick1));

  mixer_level_ctrl #(.W_LEVEL(7), .MAX_LEVEL(100), .MAX_SHIFT(8), .STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .lrclk_i(lrclk), .mute_i(mute),
    .req_valid_i(req_valid4), .req_level_i(req_level), .req_shift_i(req_shift),
    .req_ready_o(ready4), .level_o(level4), .shift_o(shift4),
    .busy_o(busy4), .done_o(done4), .frame_tick_o(tick4));

  always #5 clk = ~clk;

  // lrclk: 4 clk high, 4 clk low -> one frame every 8 cycles
  initial forever begin
    repeat (4) @(negedge clk);
    lrclk = ~lrclk;
  end

  // transfer counter for the step=1 instance
  always @(posedge clk) if (req_valid && ready1 && !rst) xfers++;

  function automatic logic [6:0] model_step(input logic [6:0] cur, input logic [6:0] tgt,
                                            input int stp);
    int c, t;
    c = int'(cur);
    t = int'(tgt);
    if (t > c) return 7'((t - c < stp) ? t : c + stp);
    if (c > t) return 7'((c - t < stp) ? t : c - stp);
    return cur;
  endfunction

  task automatic push_ramp(input logic [6:0] from, input logic [6:0] tgt, input int stp);
    logic [6:0] lv;
    lv = from;
    do begin
      lv = model_step(lv, tgt, stp);
      exp_q.push_back(lv);
    end while (lv != tgt);
  endtask

  // waits for a frame tick, then one more cycle so the stepped level is visible
  task automatic wait_tick();
    int n;
    n = 0;
    while (tick1 !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        $display("FAIL tick_timeout: no frame_tick within 40 cycles, required one");
        $fatal(1, "frame tick timeout");
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({level1, shift1, busy1, done1, ready1, tick1} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: lvl=%0d sh=%0d busy=%b done=%b rdy=%b tick=%b, required all 0",
               level1, shift1, busy1, done1, ready1, tick1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready1, busy1, done1, level1} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b done=%b lvl=%0d, required rdy=1 busy=0 done=0 lvl=0",
               ready1, busy1, done1, level1);
    end
  endtask

  task automatic test_ramp_up();
    logic [6:0] e;
    exp_q.delete();
    push_ramp(7'd0, 7'd9, 1);
    req_level = 7'd9; req_shift = 4'd8; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({busy1, ready1} !== 2'b10) begin
      errors++;
      $display("FAIL ramp_accept: busy=%b rdy=%b, required busy=1 rdy=0", busy1, ready1);
    end
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || shift1 !== 4'd8) begin
        errors++;
        $display("FAIL ramp_level: lvl=%0d sh=%0d, required lvl=%0d sh=8", level1, shift1, e);
      end
      checks++;
      if (done1 !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL ramp_done: done=%b, required %b", done1, exp_q.size() == 0);
      end
    end
    @(negedge clk);
    checks++;
    if ({done1, ready1, busy1} !== 3'b010) begin
      errors++;
      $display("FAIL ramp_end: done=%b rdy=%b busy=%b, required 0 1 0", done1, ready1, busy1);
    end
  endtask

  task automatic test_clamp_step();
    logic [6:0] e;
    exp_q.delete();
    push_ramp(7'd0, 7'd100, 4);     // request 120 saturates at max_level 100
    req_level = 7'd120; req_shift = 4'd12; req_valid4 = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0;
    checks++;
    if (exp_q.size() != 25) begin
      errors++;
      $display("FAIL clamp_tick_count: model ticks=%0d, required 25", exp_q.size());
    end
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level4 !== e || shift4 !== 4'd8) begin
        errors++;
        $display("FAIL clamp_level: lvl=%0d sh=%0d, required lvl=%0d sh=8", level4, shift4, e);
      end
      checks++;
      if (done4 !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL clamp_done: done=%b, required %b", done4, exp_q.size() == 0);
      end
    end
  endtask

  task automatic test_mute();
    logic [6:0] e;
    // mute from 9 down to 0
    exp_q.delete();
    push_ramp(7'd9, 7'd0, 1);
    mute = 1'b1;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e) begin
        errors++;
        $display("FAIL mute_down: lvl=%0d, required %0d", level1, e);
      end
      checks++;
      if (exp_q.size() == 0 ? (done1 !== 1'b1) : (ready1 !== 1'b0 || done1 !== 1'b0)) begin
        errors++;
        $display("FAIL mute_down_ctl: done=%b rdy=%b, remaining=%0d", done1, ready1, exp_q.size());
      end
    end
    // release: back up to 9
    push_ramp(7'd0, 7'd9, 1);
    mute = 1'b0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || done1 !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL mute_up: lvl=%0d done=%b, required lvl=%0d done=%b",
                 level1, done1, e, exp_q.size() == 0);
      end
    end
    // toggle mid-ramp: three steps down, then reverse
    exp_q.push_back(7'd8); exp_q.push_back(7'd7); exp_q.push_back(7'd6);
    mute = 1'b1;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || done1 !== 1'b0) begin
        errors++;
        $display("FAIL toggle_down: lvl=%0d done=%b, required lvl=%0d done=0", level1, done1, e);
      end
    end
    push_ramp(7'd6, 7'd9, 1);
    mute = 1'b0;
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || done1 !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL toggle_up: lvl=%0d done=%b, required lvl=%0d done=%b",
                 level1, done1, e, exp_q.size() == 0);
      end
    end
  endtask

  task automatic test_handshake();
    logic [6:0] e;
    int x0;
    x0 = xfers;
    exp_q.delete();
    push_ramp(7'd9, 7'd12, 1);
    req_level = 7'd12; req_shift = 4'd2; req_valid = 1'b1;
    @(negedge clk);
    // keep valid high with a new target while busy
    req_level = 7'd20; req_shift = 4'd5;
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || shift1 !== 4'd2) begin
        errors++;
        $display("FAIL hs_first: lvl=%0d sh=%0d, required lvl=%0d sh=2", level1, shift1, e);
      end
      checks++;
      if ({done1, ready1} !== ((exp_q.size() == 0) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL hs_ready: done=%b rdy=%b, remaining=%0d", done1, ready1, exp_q.size());
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({busy1, ready1} !== 2'b10) begin
      errors++;
      $display("FAIL hs_second_accept: busy=%b rdy=%b, required 1 0", busy1, ready1);
    end
    checks++;
    if (xfers - x0 !== 2) begin
      errors++;
      $display("FAIL hs_xfer_count: transfers=%0d, required 2", xfers - x0);
    end
    push_ramp(7'd12, 7'd20, 1);
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || shift1 !== 4'd5 || done1 !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL hs_second: lvl=%0d sh=%0d done=%b, required lvl=%0d sh=5",
                 level1, shift1, done1, e);
      end
    end
  endtask

  task automatic test_same_level();
    logic [6:0] e;
    exp_q.delete();
    exp_q.push_back(7'd20);
    req_level = 7'd20; req_shift = 4'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL same_busy: busy=%b, required 1", busy1);
    end
    wait_tick();
    e = exp_q.pop_front();
    checks++;
    if ({level1, shift1, done1} !== {e, 4'd7, 1'b1}) begin
      errors++;
      $display("FAIL same_level: lvl=%0d sh=%0d done=%b, required lvl=%0d sh=7 done=1",
               level1, shift1, done1, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    bit bad;
    exp_q.delete();
    push_ramp(7'd20, 7'd5, 1);
    req_level = 7'd0; req_shift = 4'd1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() > 0) begin
      wait_tick();
      e = exp_q.pop_front();
      checks++;
      if (level1 !== e || done1 !== 1'b0) begin
        errors++;
        $display("FAIL rm_ramp: lvl=%0d done=%b, required lvl=%0d done=0", level1, done1, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({level1, shift1, busy1, ready1, done1} !== 14'd0) begin
      errors++;
      $display("FAIL rm_reset: lvl=%0d sh=%0d busy=%b rdy=%b done=%b, required all 0",
               level1, shift1, busy1, ready1, done1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready: rdy=%b, required 1", ready1);
    end
    bad = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (done1 !== 1'b0 || level1 !== 7'd0 || busy1 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rm_quiet: done/level/busy activity after reset, required none");
    end
  endtask

  task automatic test_frame_tick();
    int n;
    bit wide;
    logic prev;
    n = 0; wide = 1'b0; prev = 1'b0;
    repeat (64) begin
      @(negedge clk);
      if (tick1 === 1'b1) n++;
      if (tick1 === 1'b1 && prev === 1'b1) wide = 1'b1;
      prev = tick1;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL tick_count: ticks=%0d in 64 cycles, required 8", n);
    end
    checks++;
    if (wide) begin
      errors++;
      $display("FAIL tick_width: pulse longer than one cycle, required one");
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_step();
    test_mute();
    test_handshake();
    test_same_level();
    test_reset_mid();
    test_frame_tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
